// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: round-robin I/D-cache arbiter for a four-banked memory; DCACHE_PRIORITY_EN gives requester 1 tie priority
module cache_mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_rd0,
  input  logic          req_wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req_rd1,
  input  logic          req_wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic          stall0,
  output logic          stall1,
  output logic [DW-1:0] rdata,
  output logic [1:0]    grant,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic [3:0]    mem_busy,
  input  logic          mem_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic r_id, r_wr, r_bad, r_err;
  logic [2:0] r_cnt;
  logic [1:0] r_grant;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_rdata;
  logic w_act0, w_act1, w_win, w_rd, w_wr, w_issue;
  assign w_act0 = req_rd0 | req_wr0;
  assign w_act1 = req_rd1 | req_wr1;
`ifdef DCACHE_PRIORITY_EN
  assign w_win = w_act1;
`else
  logic r_rr;
  assign w_win = w_act1 & (~w_act0 | r_rr);
  always_ff @(posedge clk) begin
    if (!rst) r_rr <= 1'b0;
    else if (r_state == DONE) r_rr <= ~r_id;
  end
`endif
  assign w_rd = w_win ? req_rd1 : req_rd0;
  assign w_wr = w_win ? req_wr1 : req_wr0;
  // a malformed rd+wr request passes through ISSUE without touching memory
  assign w_issue = (r_state == ISSUE) & ~r_bad & ~mem_busy[r_addr[2:1]];
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? ((w_act0 | w_act1) ? ISSUE : IDLE) :
             r_state == ISSUE ? (r_bad ? DONE : w_issue ? WAIT : ISSUE) :
             r_state == WAIT  ? ((r_cnt == 3'd1) ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_id    <= 1'b0;
      r_wr    <= 1'b0;
      r_bad   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 3'd0;
      r_grant <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && (w_act0 | w_act1)) begin
        r_id    <= w_win;
        r_wr    <= w_wr;
        r_bad   <= w_rd & w_wr;
        r_err   <= w_rd & w_wr;
        r_addr  <= w_win ? addr1 : addr0;
        r_wdata <= w_win ? wdata1 : wdata0;
        r_grant <= {w_win, ~w_win};
      end
      if (w_issue) begin
        r_cnt <= 3'(RD_LAT);
        r_err <= 1'b0;
      end
      if (r_state == WAIT) begin
        r_cnt <= r_cnt - 3'd1;
        r_err <= r_err | mem_err;
        if (r_cnt == 3'd1 && !r_wr) r_rdata <= mem_rdata;
      end
      if (r_state == DONE) r_grant <= 2'b00;
    end
  end
  assign done0     = (r_state == DONE) & ~r_id;
  assign done1     = (r_state == DONE) & r_id;
  assign err0      = done0 & r_err;
  assign err1      = done1 & r_err;
  assign stall0    = w_act0 & ~done0;
  assign stall1    = w_act1 & ~done1;
  assign rdata     = r_rdata;
  assign grant     = r_grant;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_rd    = w_issue & ~r_wr;
  assign mem_wr    = w_issue & r_wr;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: random two-requester traffic against a transaction-level arbiter and memory model
module tb_cache_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_rd0 = 0, req_wr0 = 0, req_rd1 = 0, req_wr1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic done0, done1, err0, err1, stall0, stall1, mem_rd, mem_wr;
  logic [DW-1:0] rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0] grant;
  logic [AW-1:0] mem_addr;
  logic [3:0] mem_busy = '0;
  logic mem_err = 1'b0;
  always #5 clk = ~clk;
  cache_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_rd0(req_rd0), .req_wr0(req_wr0), .addr0(addr0), .wdata0(wdata0),
    .req_rd1(req_rd1), .req_wr1(req_wr1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .stall0(stall0), .stall1(stall1), .rdata(rdata), .grant(grant),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_err(mem_err)
  );
  int n_checks = 0;
  int n_errors = 0;
  task automatic check(input string tag, input int t, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask
  logic [DW-1:0] mem [256];
  int due_t = -1;
  logic [DW-1:0] due_d = '0;
  logic [1:0] q_rd = '0, q_wr = '0, done_prev = '0;
  logic [AW-1:0] q_addr [2];
  logic [DW-1:0] q_wdata [2];
  int owner = -1;
  int t_done = -1, t_strobe = -100;
  bit rr = 0, waiting = 0, m_bad = 0, m_err = 0;
  int m_id = 0;
  bit m_rd = 0, m_wr = 0;
  logic [AW-1:0] m_addr = '0, exp_ma = '0;
  logic [DW-1:0] m_wdata = '0, exp_mw = '0, m_data = '0, last_rdata = '0;
  int model_dones = 0, dut_dones = 0;
  task automatic start_new(input int i, input bit force_rd);
    int k = $urandom_range(9);
    q_rd[i] = force_rd || k == 0 || k >= 5;
    q_wr[i] = !force_rd && k <= 4;
    q_addr[i] = AW'($urandom);
    q_wdata[i] = DW'($urandom);
  endtask
  task automatic drive(input int t);
    rst = (t < 3) ? 1'b0 : (t != 3 && $urandom_range(199) == 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (done_prev[i]) begin
        q_rd[i] = 0;
        q_wr[i] = 0;
        if ($urandom_range(1) == 0) start_new(i, 0);
      end else if (!(q_rd[i] | q_wr[i])) begin
        if (t == 3) start_new(i, 1);
        else if (t > 3 && $urandom_range(2) == 0) start_new(i, 0);
      end else if (owner != i && $urandom_range(15) == 0) begin
        q_rd[i] = 0;
        q_wr[i] = 0;
      end else if (owner == i && $urandom_range(7) == 0) begin
        q_addr[i] = AW'($urandom);
        q_wdata[i] = DW'($urandom);
      end
    end
    req_rd0 = q_rd[0]; req_wr0 = q_wr[0]; addr0 = q_addr[0]; wdata0 = q_wdata[0];
    req_rd1 = q_rd[1]; req_wr1 = q_wr[1]; addr1 = q_addr[1]; wdata1 = q_wdata[1];
    for (int b = 0; b < 4; b++) mem_busy[b] = ($urandom_range(3) == 0);
    mem_err = ($urandom_range(7) == 0);
    mem_rdata = (due_t == t) ? due_d : DW'($urandom);
  endtask
  task automatic check_cycle(input int t);
    logic [1:0] act, de, eg;
    bit str_ok;
    logic [DW-1:0] er;
    act = q_rd | q_wr;
    de[0] = (owner == 0 && t == t_done);
    de[1] = (owner == 1 && t == t_done);
    str_ok = owner >= 0 && waiting && !m_bad && !mem_busy[m_addr[2:1]];
    eg = (owner < 0) ? 2'b00 : (m_id == 1) ? 2'b10 : 2'b01;
    er = (de != 0 && m_rd && !m_bad) ? m_data : last_rdata;
    check("done0", t, 32'(done0), 32'(de[0]));
    check("done1", t, 32'(done1), 32'(de[1]));
    check("err0", t, 32'(err0), 32'(de[0] & (m_bad | m_err)));
    check("err1", t, 32'(err1), 32'(de[1] & (m_bad | m_err)));
    check("stall0", t, 32'(stall0), 32'(act[0] & ~de[0]));
    check("stall1", t, 32'(stall1), 32'(act[1] & ~de[1]));
    check("grant", t, 32'(grant), 32'(eg));
    check("mem_rd", t, 32'(mem_rd), 32'(str_ok & m_rd));
    check("mem_wr", t, 32'(mem_wr), 32'(str_ok & m_wr));
    check("mem_addr", t, 32'(mem_addr), 32'(exp_ma));
    check("mem_wdata", t, 32'(mem_wdata), 32'(exp_mw));
    check("rdata", t, 32'(rdata), 32'(er));
    dut_dones += int'(done0) + int'(done1);
    if (de != 0) model_dones++;
    done_prev = de;
    if (mem_rd) begin
      due_t = t + LAT;
      due_d = mem[mem_addr[7:0]];
    end
    if (mem_wr) mem[mem_addr[7:0]] = mem_wdata;
    if (!rst) begin
      owner = -1; rr = 0; last_rdata = '0; exp_ma = '0; exp_mw = '0; waiting = 0;
    end else if (owner >= 0) begin
      if (str_ok) begin
        waiting = 0; t_strobe = t; t_done = t + LAT + 1; m_err = 0;
        m_data = mem[m_addr[7:0]];
      end else if (!waiting && t > t_strobe && t <= t_strobe + LAT) m_err = m_err | mem_err;
      if (t == t_done) begin
        if (m_rd && !m_bad) last_rdata = m_data;
`ifndef DCACHE_PRIORITY_EN
        rr = (m_id == 0);
`endif
        owner = -1;
      end
    end else if (act != 0) begin
`ifdef DCACHE_PRIORITY_EN
      m_id = act[1] ? 1 : 0;
`else
      m_id = (act == 2'b11) ? int'(rr) : act[1] ? 1 : 0;
`endif
      owner = m_id;
      m_rd = q_rd[m_id]; m_wr = q_wr[m_id];
      m_addr = q_addr[m_id]; m_wdata = q_wdata[m_id];
      m_bad = m_rd & m_wr; waiting = 1; m_err = 0; t_strobe = -100;
      t_done = m_bad ? t + 2 : -1;
      exp_ma = m_addr; exp_mw = m_wdata;
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    q_addr[0] = '0; q_addr[1] = '0; q_wdata[0] = '0; q_wdata[1] = '0;
    for (int t = 0; t < 4000; t++) begin
      @(posedge clk);
      #1;
      drive(t);
      @(negedge clk);
      check_cycle(t);
    end
    check("done_count", 4000, 32'(dut_dones), 32'(model_dones));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
